// File: rtl/uart_rx_pkt_ctrl.sv
// UART receive-path controller: 16x baud tick generator plus a framed-packet
// parser (SOF, LEN, payload, checksum) that feeds payload bytes to a FIFO.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_HUNT    | waiting for SOF_BYTE, all other bytes ignored
// ST_LEN     | SOF seen, next byte is the payload length
// ST_PAYLOAD | forwarding payload bytes, accumulating the checksum
// ST_CSUM    | all payload received, next byte is the checksum
module uart_rx_pkt_ctrl #(
   parameter int         DVSR       = 163,
   parameter int         DVSR_BIT   = 8,
   parameter logic [7:0] SOF_BYTE   = 8'hA5,
   parameter int         MAX_LEN    = 32,
   parameter int         TOUT_TICKS = 480
) (
   input  logic       clk,
   input  logic       reset,
   output logic       s_tick,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   input  logic       fifo_full,
   output logic       pkt_wr,
   output logic [7:0] pkt_data,
   output logic       pkt_done,
   output logic       pkt_err,
   output logic [2:0] err_code,
   output logic [7:0] pkt_len
);

   localparam int TOUT_W = $clog2(TOUT_TICKS);
   localparam logic [DVSR_BIT-1:0] DVSR_LAST = DVSR_BIT'(DVSR - 1);
   localparam logic [DVSR_BIT-1:0] DVSR_PRE  = DVSR_BIT'(DVSR - 2);
   localparam logic [TOUT_W-1:0]   TOUT_LAST = TOUT_W'(TOUT_TICKS - 1);
   localparam logic [7:0]          LEN_MAX   = 8'(MAX_LEN);

   localparam logic [2:0] ERR_LEN  = 3'd1;
   localparam logic [2:0] ERR_CSUM = 3'd2;
   localparam logic [2:0] ERR_TOUT = 3'd3;
   localparam logic [2:0] ERR_OVF  = 3'd4;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM
   } state_t;

   state_t                state;
   logic [DVSR_BIT-1:0]   baud_cnt;
   logic [TOUT_W-1:0]     tout_cnt;
   logic [7:0]            rem_cnt;
   logic [7:0]            len_reg;
   logic [7:0]            csum;

   // s_tick is registered one cycle ahead of the wrap so it lines up with
   // baud_cnt == DVSR-1 without a combinational decode on the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         baud_cnt <= '0;
         s_tick   <= 1'b0;
      end else begin
         baud_cnt <= (baud_cnt == DVSR_LAST) ? '0 : baud_cnt + 1'b1;
         s_tick   <= (baud_cnt == DVSR_PRE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_HUNT;
         tout_cnt <= '0;
         rem_cnt  <= '0;
         len_reg  <= '0;
         csum     <= '0;
         pkt_wr   <= 1'b0;
         pkt_data <= '0;
         pkt_done <= 1'b0;
         pkt_err  <= 1'b0;
         err_code <= '0;
         pkt_len  <= '0;
      end else begin
         pkt_wr   <= 1'b0;
         pkt_done <= 1'b0;
         pkt_err  <= 1'b0;
         if (rx_done_tick) begin
            // a byte arriving with the expiring tick wins over the timeout
            tout_cnt <= '0;
            case (state)
               ST_HUNT: begin
                  if (rx_data == SOF_BYTE) state <= ST_LEN;
               end
               ST_LEN: begin
                  if (rx_data == 8'd0 || rx_data > LEN_MAX) begin
                     pkt_err  <= 1'b1;
                     err_code <= ERR_LEN;
                     state    <= ST_HUNT;
                  end else begin
                     len_reg <= rx_data;
                     rem_cnt <= rx_data;
                     csum    <= rx_data;
                     state   <= ST_PAYLOAD;
                  end
               end
               ST_PAYLOAD: begin
                  if (fifo_full) begin
                     pkt_err  <= 1'b1;
                     err_code <= ERR_OVF;
                     state    <= ST_HUNT;
                  end else begin
                     pkt_wr   <= 1'b1;
                     pkt_data <= rx_data;
                     csum     <= csum + rx_data;
                     rem_cnt  <= rem_cnt - 1'b1;
                     if (rem_cnt == 8'd1) state <= ST_CSUM;
                  end
               end
               ST_CSUM: begin
                  if (rx_data == csum) begin
                     pkt_done <= 1'b1;
                     pkt_len  <= len_reg;
                  end else begin
                     pkt_err  <= 1'b1;
                     err_code <= ERR_CSUM;
                  end
                  state <= ST_HUNT;
               end
               default: state <= ST_HUNT;
            endcase
         end else if (state == ST_HUNT) begin
            tout_cnt <= '0;
         end else if (s_tick) begin
            if (tout_cnt == TOUT_LAST) begin
               pkt_err  <= 1'b1;
               err_code <= ERR_TOUT;
               state    <= ST_HUNT;
               tout_cnt <= '0;
            end else begin
               tout_cnt <= tout_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl: expected writes/done/errors are
// queued as bytes are driven and matched by a monitor as the DUT emits them.
module tb_uart_rx_pkt_ctrl;

   localparam int DVSR = 163;
   localparam int TOUT = 480;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_tick;
   logic       rx_done_tick = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       fifo_full = 1'b0;
   logic       pkt_wr;
   logic [7:0] pkt_data;
   logic       pkt_done;
   logic       pkt_err;
   logic [2:0] err_code;
   logic [7:0] pkt_len;

   uart_rx_pkt_ctrl dut (
      .clk(clk), .reset(reset), .s_tick(s_tick),
      .rx_done_tick(rx_done_tick), .rx_data(rx_data), .fifo_full(fifo_full),
      .pkt_wr(pkt_wr), .pkt_data(pkt_data), .pkt_done(pkt_done),
      .pkt_err(pkt_err), .err_code(err_code), .pkt_len(pkt_len)
   );

   always #5 clk = ~clk;

   // kind: 0 = payload write, 1 = packet done, 2 = packet error
   typedef struct {
      int         kind;
      logic [7:0] val;
   } ev_t;

   ev_t sb[$];
   int  vectors = 0;
   int  miscompares = 0;
   logic rx_q = 1'b0;

   always @(posedge clk) rx_q <= rx_done_tick;

   always @(negedge clk) begin
      if (!reset) begin
         if ((pkt_done && pkt_err) || (pkt_wr && pkt_err)) begin
            vectors++;
            miscompares++;
            $display("FAIL exclusivity: wr=%0b done=%0b err=%0b", pkt_wr, pkt_done, pkt_err);
         end
         if (pkt_wr || pkt_done || pkt_err) begin
            ev_t exp;
            ev_t act;
            act.kind = pkt_wr ? 0 : (pkt_done ? 1 : 2);
            act.val  = pkt_wr ? pkt_data : (pkt_done ? pkt_len : {5'd0, err_code});
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_event: got kind=%0d val=%02h, required none", act.kind, act.val);
            end else begin
               exp = sb.pop_front();
               if (act.kind !== exp.kind || act.val !== exp.val) begin
                  miscompares++;
                  $display("FAIL event: got kind=%0d val=%02h, required kind=%0d val=%02h",
                           act.kind, act.val, exp.kind, exp.val);
               end
            end
            if ((pkt_wr || pkt_done) && !rx_q) begin
               vectors++;
               miscompares++;
               $display("FAIL latency: kind=%0d not 1 clk after a strobe", act.kind);
            end
         end
      end
   end

   task automatic push(input int kind, input logic [7:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic full);
      @(posedge clk);
      #1;
      rx_done_tick = 1'b1;
      rx_data      = b;
      fifo_full    = full;
      @(posedge clk);
      #1;
      rx_done_tick = 1'b0;
      fifo_full    = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL %s drain: %0d events outstanding, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({s_tick, pkt_wr, pkt_done, pkt_err, err_code, pkt_len, pkt_data} !== 22'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, required 0",
                  {s_tick, pkt_wr, pkt_done, pkt_err, err_code, pkt_len, pkt_data});
      end
   endtask

   task automatic test_baud();
      int bad = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         logic exp_t;
         exp_t = ((i % DVSR) == DVSR - 1);
         vectors++;
         if (s_tick !== exp_t) begin
            miscompares++;
            bad++;
            if (bad < 8) $display("FAIL s_tick cycle %0d: got %0b, required %0b", i, s_tick, exp_t);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_good_packet();
      send_byte(8'hA5, 0); send_byte(8'h03, 0);
      push(0, 8'h11); send_byte(8'h11, 0);
      push(0, 8'h22); send_byte(8'h22, 0);
      push(0, 8'h33); send_byte(8'h33, 0);
      push(1, 8'd3);  send_byte(8'h69, 0);
      drain("good_packet", 20);
      vectors++;
      if (pkt_len !== 8'd3) begin
         miscompares++;
         $display("FAIL pkt_len_held: got %0d, required 3", pkt_len);
      end
   endtask

   task automatic test_bad_csum();
      send_byte(8'h00, 0); send_byte(8'hA5, 0); send_byte(8'h02, 0);
      push(0, 8'h10); send_byte(8'h10, 0);
      push(0, 8'h20); send_byte(8'h20, 0);
      push(2, 8'd2);  send_byte(8'hFF, 0);
      drain("bad_csum", 20);
   endtask

   task automatic test_bad_len();
      send_byte(8'hA5, 0); push(2, 8'd1); send_byte(8'h00, 0);
      send_byte(8'hA5, 0); push(2, 8'd1); send_byte(8'h21, 0);
      drain("bad_len", 20);
   endtask

   task automatic test_max_len();
      logic [7:0] cs = 8'd32;
      send_byte(8'hA5, 0); send_byte(8'd32, 0);
      for (int i = 0; i < 32; i++) begin
         logic [7:0] b;
         b  = 8'(i * 7 + 3);
         cs = cs + b;
         push(0, b);
         send_byte(b, 0);
      end
      push(1, 8'd32);
      send_byte(cs, 0);
      drain("max_len", 20);
   endtask

   task automatic test_back_to_back();
      // SOF value inside the payload is data; then an immediate second frame
      send_byte(8'hA5, 0); send_byte(8'h02, 0);
      push(0, 8'hA5); send_byte(8'hA5, 0);
      push(0, 8'hA5); send_byte(8'hA5, 0);
      push(1, 8'd2);  send_byte(8'h4C, 0);
      send_byte(8'hA5, 0); send_byte(8'h01, 0);
      push(0, 8'hFE); send_byte(8'hFE, 0);
      push(1, 8'd1);  send_byte(8'hFF, 0);
      drain("back_to_back", 20);
   endtask

   task automatic test_timeout();
      int ticks = 0;
      int n = 0;
      send_byte(8'hA5, 0); send_byte(8'h04, 0);
      push(0, 8'h01); send_byte(8'h01, 0);
      @(negedge clk);
      while (sb.size() != 0) @(negedge clk);
      push(2, 8'd3);
      while (!pkt_err && n < TOUT * DVSR + 500) begin
         @(negedge clk);
         if (s_tick) ticks++;
         n++;
      end
      vectors++;
      if (ticks !== TOUT) begin
         miscompares++;
         $display("FAIL timeout_ticks: got %0d s_ticks before error, required %0d", ticks, TOUT);
      end
      drain("timeout", 10);
      send_byte(8'hA5, 0); send_byte(8'h01, 0);
      push(0, 8'h07); send_byte(8'h07, 0);
      push(1, 8'd1);  send_byte(8'h08, 0);
      drain("after_timeout", 20);
   endtask

   task automatic test_overflow_and_reset();
      send_byte(8'hA5, 0); send_byte(8'h02, 0);
      push(0, 8'h55); send_byte(8'h55, 0);
      push(2, 8'd4);  send_byte(8'hAA, 1);
      drain("overflow", 20);
      vectors++;
      if (err_code !== 3'd4) begin
         miscompares++;
         $display("FAIL err_code_held: got %0d, required 4", err_code);
      end
      send_byte(8'hA5, 0); send_byte(8'h03, 0);
      push(0, 8'h12); send_byte(8'h12, 0);
      drain("pre_reset", 20);
      do_reset();
      #1;
      vectors++;
      if ({pkt_wr, pkt_done, pkt_err, err_code, pkt_len} !== 14'd0) begin
         miscompares++;
         $display("FAIL midframe_reset: got %h, required 0", {pkt_wr, pkt_done, pkt_err, err_code, pkt_len});
      end
      // leftover payload bytes must be ignored in hunt; monitor flags any output
      send_byte(8'h34, 0); send_byte(8'h56, 0);
      repeat (5) @(posedge clk);
      send_byte(8'hA5, 0); send_byte(8'h01, 0);
      push(0, 8'h09); send_byte(8'h09, 0);
      push(1, 8'd1);  send_byte(8'h0A, 0);
      drain("after_reset", 20);
   endtask

   initial begin
      test_reset();
      test_baud();
      test_good_packet();
      test_bad_csum();
      test_bad_len();
      test_max_len();
      test_back_to_back();
      test_timeout();
      test_overflow_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
Controller that sequences the UART receive path. It generates the 16x-oversampling s_tick that paces the receiver. It consumes the receiver's rx_done_tick/dout byte stream and parses framed command packets: SOF, LEN, payload, checksum. Payload bytes are forwarded to a downstream FIFO, and the controller reports packet completion or a coded error, including inter-byte timeout and FIFO overflow.

Parameters:
DVSR, 163, baud divisor; s_tick pulses once every DVSR clocks (50 MHz / (16 x 19200)).
DVSR_BIT, 8, width of the baud counter.
SOF_BYTE, 8'hA5, start-of-frame marker.
MAX_LEN, 32, maximum legal payload length (1..255).
TOUT_TICKS, 480, inter-byte timeout measured in s_tick pulses (about 3 byte-times).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s_tick  out  1  one-clock baud oversample tick to the receiver
rx_done_tick  in  1  one-clock strobe from the receiver: byte valid
rx_data  in  8  received byte, valid when rx_done_tick=1
fifo_full  in  1  downstream FIFO full
pkt_wr  out  1  one-clock write strobe for pkt_data
pkt_data  out  8  payload byte
pkt_done  out  1  one-clock pulse: packet accepted, checksum good
pkt_err  out  1  one-clock pulse: packet aborted
err_code  out  3  code of the last error, held until the next error or reset
pkt_len  out  8  LEN of the last good packet, held

Behaviour:
- Reset: all outputs 0; baud counter 0; state = hunt; timeout counter 0; checksum 0.
- Baud generator is free-running and independent of the FSM.
  - Counter counts 0..DVSR-1 and wraps.
  - s_tick=1 in the cycle the counter equals DVSR-1.
- The FSM acts only on cycles with rx_done_tick=1. All outputs are registered: pulses appear exactly 1 clock after the triggering rx_done_tick.
- States and transitions:
  - hunt: byte==SOF_BYTE -> len. Any other byte is ignored and produces no output.
  - len:
    - byte==0 or byte>MAX_LEN -> pkt_err, err_code=3'd1, go to hunt.
    - Otherwise latch the count, set checksum=byte, go to payload.
  - payload:
    - Each byte: checksum += byte (mod 256), remaining count decrements.
    - If fifo_full=0: pkt_wr=1 and pkt_data=byte.
    - If fifo_full=1 (sampled in the rx_done_tick cycle): the byte is dropped, pkt_err, err_code=3'd4, go to hunt.
    - After the LEN-th payload byte -> csum.
  - csum:
    - byte==checksum -> pkt_done=1, pkt_len=LEN.
    - Otherwise -> pkt_err, err_code=3'd2.
    - Either way go to hunt.
- Timeout:
  - In len, payload and csum, the timeout counter increments on each s_tick and clears on each rx_done_tick.
  - When s_tick arrives with the counter at TOUT_TICKS-1: pkt_err, err_code=3'd3, go to hunt, counter cleared.
  - The counter is held at 0 in hunt.
- Simultaneous events:
  - rx_done_tick in the same cycle as timeout expiry: the byte wins and is processed normally; the counter clears.
  - A SOF_BYTE value arriving inside LEN/payload/csum is treated as data, not resync.
- Output exclusivity: pkt_done and pkt_err are never high together. pkt_wr is never high in the cycle of pkt_err.
- Reset mid-packet: immediate abort; no pkt_err is issued; state = hunt.
- Checksum width: 8 bits, wrap-around addition covering LEN plus all payload bytes.

Test Plan:
- Reset, then run 1000 clocks with DVSR=163 -> s_tick pulses at clocks 162, 325, 488..., each exactly 1 cycle wide.
- Bytes A5,03,11,22,33,69 (69 = 03+11+22+33) -> pkt_wr with data 11,22,33 each 1 clk after its strobe; pkt_done 1 clk after byte 69; pkt_len=3; no pkt_err.
- Bytes 00,A5,02,10,20,FF -> leading 00 ignored; 2 writes (10,20); pkt_err with err_code=2; pkt_done stays 0.
- Bytes A5,00, then A5,21 with MAX_LEN=32 -> pkt_err with err_code=1 after each LEN byte; no pkt_wr.
- Bytes A5,04,01 then silence -> after 480 s_ticks, pkt_err with err_code=3. A following A5,01,07,08 frame is accepted (pkt_done, pkt_len=1).
- Bytes A5,02,55 with fifo_full raised before the 2nd payload byte AA -> 1 write (55); AA dropped; pkt_err with err_code=4. Assert reset mid-frame -> all outputs 0 and no error pulse.
